// File: rtl/sccpu_pkg.sv
// Shared definitions for the single-cycle CPU fetch slice: next-PC select
// encodings, the fetch state type and the default reset vector.
package sccpu_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sccpu_npc.sv
// Next-PC selection: sequential, PC-relative branch, register jump and
// pseudo-direct jump targets, all modulo 2^32.
module sccpu_npc
  import sccpu_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [31:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc
);

  logic [31:0] br_off;
  logic        unused_op_bits;

  assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};
  // The opcode field plays no part in target arithmetic.
  assign unused_op_bits = ^inst[31:26];

  always_comb begin
    npc = pc4;
    case (pcsource)
      PC_SEQ:  npc = pc4;
      PC_BR:   npc = pc4 + br_off;
      PC_JR:   npc = ra & 32'hFFFF_FFFC;
      PC_J:    npc = {pc4[31:28], inst[25:0], 2'b00};
      default: npc = pc4;
    endcase
  end

endmodule

// File: rtl/sccpu_ifetch.sv
// Instruction fetch unit: FETCH/WAIT/EXEC handshake with instruction memory,
// latches the instruction word and advances the PC when execution releases it.
module sccpu_ifetch
  import sccpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  pcsource,
  input  logic [31:0] ra,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        misalign
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg;
  logic [31:0]  inst_reg;
  logic [31:0]  npc;
  logic         latch_inst;
  logic         advance;

  sccpu_npc u_npc (
    .pc4      (pc4),
    .inst     (inst_reg),
    .ra       (ra),
    .pcsource (pcsource),
    .npc      (npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FETCH;
      pc_reg    <= RESET_PC;
      inst_reg  <= 32'h0;
    end else begin
      state_reg <= state_next;
      if (latch_inst) inst_reg <= imem_rdata;
      if (advance)    pc_reg   <= npc;
    end
  end

  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    latch_inst = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      FETCH, WAIT: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          latch_inst = 1'b1;
          state_next = EXEC;
        end else begin
          state_next = WAIT;
        end
      end
      EXEC: begin
        if (!stall) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
  end

  assign imem_addr  = pc_reg;
  assign pc         = pc_reg;
  assign pc4        = pc_reg + 32'd4;
  assign inst       = inst_reg;
  assign op         = inst_reg[31:26];
  assign func       = inst_reg[5:0];
  assign inst_valid = (state_reg == EXEC);
  // Flag only the cycle that actually commits a misaligned jr target.
  assign misalign   = !rst && advance && (pcsource == PC_JR) && (ra[1:0] != 2'b00);

endmodule

// File: doc/sccpu_ifetch.md
SCCPU_IFETCH -- requirements
Module: sccpu_ifetch

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, the PC value loaded by reset.
REQ-002 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: imem_req  output  1  instruction-memory read request.
REQ-005 Port: imem_addr  output  32  word-aligned fetch address; equals pc.
REQ-006 Port: imem_ack  input  1  read data valid; may be asserted in the same cycle as imem_req.
REQ-007 Port: imem_rdata  input  32  instruction word, sampled when imem_req and imem_ack are both high.
REQ-008 Port: pcsource  input  2  next-PC select from the control decoder: 00 pc+4, 01 branch, 10 jr, 11 j/jal.
REQ-009 Port: ra  input  32  register-file rs value; the jr target.
REQ-010 Port: stall  input  1  downstream hold; while high, the current instruction is retained.
REQ-011 Port: inst_valid  output  1  high while the latched instruction is presented for execution.
REQ-012 Port: inst  output  32  latched instruction word.
REQ-013 Port: op  output  6  inst[31:26], feeding the control decoder.
REQ-014 Port: func  output  6  inst[5:0], feeding the control decoder.
REQ-015 Port: pc  output  32  address of the current instruction.
REQ-016 Port: pc4  output  32  pc+4; also the jal link value.
REQ-017 Port: misalign  output  1  one-cycle pulse when a jr target has nonzero bits [1:0].

Function
REQ-018 The state machine SHALL have three states: FETCH, WAIT, EXEC.
REQ-019 FETCH: imem_req=1; on imem_ack, latch imem_rdata into inst and go to EXEC; otherwise go to WAIT.
REQ-020 WAIT: imem_req=1 with imem_addr held stable; on imem_ack, latch inst and go to EXEC.
REQ-021 EXEC: inst_valid=1 and imem_req=0; if stall=0, load pc with npc and go to FETCH; if stall=1, remain in EXEC with pc and inst unchanged.
REQ-022 npc SHALL be selected by pcsource as follows:
- 00: pc4
- 01: pc4 + (sign-extended inst[15:0] << 2)
- 10: {ra[31:2], 2'b00}
- 11: {pc4[31:28], inst[25:0], 2'b00}
REQ-023 All PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.
REQ-024 misalign SHALL pulse for exactly one cycle, on the EXEC cycle that leaves with pcsource=10 and ra[1:0]!=0.
REQ-025 pcsource and ra SHALL be ignored outside EXEC, and while stall=1.
REQ-026 Minimum throughput SHALL be 2 cycles per instruction, with a zero-wait imem.
REQ-027 Each additional cycle of imem_ack latency SHALL add exactly one WAIT cycle.
REQ-028 op, func and pc4 SHALL be combinational functions of inst and pc.

Reset
REQ-029 While rst is high at a clock edge, the block SHALL load the following: state=FETCH, pc=RESET_PC, inst=0, inst_valid=0, misalign=0.
REQ-030 Reset SHALL take priority over every other event, including an imem_ack arriving in that cycle, which is discarded.
REQ-031 In the first cycle after reset deasserts, imem_req=1 with imem_addr=RESET_PC.

Structure
REQ-032 Shared package sccpu_pkg SHALL contain the following:
- pcsource encoding constants PC_SEQ, PC_BR, PC_JR, PC_J
- the fetch state enum
- the default RESET_PC
REQ-033 Next-PC selection SHALL be one combinational sub-module, sccpu_npc, with inputs pc4, inst, ra and pcsource and output npc.

Verification
REQ-034 Sequential: zero-wait imem, pcsource=00 throughout -> pc sequence 0,4,8,C; inst_valid high every second cycle.
REQ-035 Taken branch: pc=0x10, inst[15:0]=0xFFFE, pcsource=01 -> next pc=0x0C; with inst[15:0]=0x0003 -> next pc=0x20.
REQ-036 Jumps: pc=0x1000_0040, inst[25:0]=0x000_0100, pcsource=11 -> next pc=0x1000_0400; pcsource=10 with ra=0x0000_2003 -> next pc=0x2000 and misalign pulses once.
REQ-037 Handshake: imem_ack delayed 3 cycles -> 3 WAIT cycles, imem_addr stable throughout, inst latched only on ack.
REQ-038 Stall: stall=1 for 4 EXEC cycles -> pc, inst and inst_valid held; pcsource changes during the stall are ignored; advance occurs on the first cycle with stall=0.
REQ-039 Reset mid-WAIT, with ack arriving in the reset cycle -> ack data discarded, pc=RESET_PC, fetch restarts in FETCH.
